// File: rtl/program_loader_if.sv
// Byte-wide valid/ready channel carrying the program image into the loader.
interface program_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    // Host side drives bytes; loader side answers with ready.
    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/program_loader.sv
// Byte-serial loader for the CPU instruction store. Parses a framed image
// (16-bit LE word count, LE data words, XOR checksum byte), writes words
// directly into the registered store and keeps the CPU in reset until a
// complete image with a matching checksum has landed.
module program_loader #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    program_loader_if.slave          host,
    output logic [DEPTH*WIDTH-1:0]   instruction_stream,
    output logic [15:0]              words_loaded,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic                     cpu_hold
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        IDLE, HDR_LO, HDR_HI, DATA, CHK, DONE, ERROR
    } state_t;

    state_t state, next_state;

    logic [DEPTH-1:0][WIDTH-1:0] store;
    logic [IW-1:0]               word_idx;
    logic [1:0]                  byte_idx;
    logic [15:0]                 count;
    logic [23:0]                 asm_q;     // bytes 0..2 of the word being assembled
    logic [7:0]                  csum;
    logic                        in_ready_q;

    logic        xfer;
    logic        restart;
    logic [15:0] hdr_count;
    logic        hdr_bad;
    logic        last_word;

    assign instruction_stream = store;
    assign host.in_ready      = in_ready_q;

    assign xfer      = host.in_valid & in_ready_q;
    assign restart   = start && (state == IDLE || state == DONE || state == ERROR);
    assign hdr_count = {host.in_data, count[7:0]};
    assign hdr_bad   = (hdr_count == 16'd0) || ({1'b0, hdr_count} > 17'(DEPTH));
    assign last_word = (32'(word_idx) == (32'(count) - 32'd1));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // Next-state decode.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERROR: if (start) next_state = HDR_LO;
            HDR_LO:            if (xfer)  next_state = HDR_HI;
            HDR_HI:            if (xfer)  next_state = hdr_bad ? ERROR : DATA;
            DATA:              if (xfer && byte_idx == 2'd3 && last_word) next_state = CHK;
            CHK:               if (xfer)  next_state = (host.in_data == csum) ? DONE : ERROR;
            default:           next_state = IDLE;
        endcase
    end

    // Status outputs are registered off the next state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_hold   <= 1'b1;
        end else begin
            in_ready_q <= (next_state == HDR_LO) || (next_state == HDR_HI) ||
                          (next_state == DATA)   || (next_state == CHK);
            busy       <= (next_state == HDR_LO) || (next_state == HDR_HI) ||
                          (next_state == DATA)   || (next_state == CHK);
            done       <= (next_state == DONE);
            error      <= (next_state == ERROR);
            cpu_hold   <= (next_state != DONE);
        end
    end

    // Frame datapath: header capture, word assembly, store writes, checksum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            store        <= '0;
            words_loaded <= '0;
            word_idx     <= '0;
            byte_idx     <= '0;
            count        <= '0;
            asm_q        <= '0;
            csum         <= '0;
        end else if (restart) begin
            // A new load starts from a blank store so stale code never runs.
            store        <= '0;
            words_loaded <= '0;
            word_idx     <= '0;
            byte_idx     <= '0;
            asm_q        <= '0;
            csum         <= '0;
        end else if (xfer) begin
            case (state)
                HDR_LO: count[7:0] <= host.in_data;
                HDR_HI: begin
                    count[15:8] <= host.in_data;
                    byte_idx    <= '0;
                    word_idx    <= '0;
                end
                DATA: begin
                    csum <= csum ^ host.in_data;
                    if (byte_idx == 2'd3) begin
                        // Commit on the 4th byte using the live byte as bits [31:24].
                        store[word_idx] <= {host.in_data, asm_q};
                        words_loaded    <= words_loaded + 16'd1;
                        word_idx        <= word_idx + 1'b1;
                    end else begin
                        asm_q[byte_idx*8 +: 8] <= host.in_data;
                    end
                    byte_idx <= byte_idx + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: framed loads, header rejects, checksum
// errors, full-depth streaming, gapped input, async reset and reload.
module tb_program_loader;

    localparam int DEPTH = 1024;
    localparam int WIDTH = 32;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic [DEPTH*WIDTH-1:0] stream;
    logic [15:0]            words_loaded;
    logic                   busy, done, error, cpu_hold;

    int passed = 0;
    int total  = 0;
    int stalls = 0;

    program_loader_if bus ();

    program_loader #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .host               (bus.slave),
        .instruction_stream (stream),
        .words_loaded       (words_loaded),
        .busy               (busy),
        .done               (done),
        .error              (error),
        .cpu_hold           (cpu_hold)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] w(input int i);
        return stream[i*32 +: 32];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Present one byte and wait (bounded) for it to be taken on a rising edge.
    task automatic send(input logic [7:0] b, input bit keep);
        int n = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        if (!bus.in_ready) stalls++;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        if (!keep) bus.in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // 3-word image: 04030201, 40302010, DDCCBBAA; XOR of data = 0x44.
    task automatic load3(input bit gaps, input string tag);
        logic [7:0] img [15] = '{8'h03, 8'h00,
                                 8'h01, 8'h02, 8'h03, 8'h04,
                                 8'h10, 8'h20, 8'h30, 8'h40,
                                 8'hAA, 8'hBB, 8'hCC, 8'hDD,
                                 8'h44};
        pulse_start();
        for (int i = 0; i < 15; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) idle_cycle();
            if (i == 14) chk({tag, "_done_before"}, 32'(done), 32'd0);
            send(img[i], !gaps);
        end
        bus.in_valid = 1'b0;
        chk({tag, "_done_after"}, 32'(done), 32'd1);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_w0"}, w(0), 32'h04030201);
        chk({tag, "_w1"}, w(1), 32'h40302010);
        chk({tag, "_w2"}, w(2), 32'hDDCCBBAA);
        chk({tag, "_w3"}, w(3), 32'h0);
        chk({tag, "_wl"}, 32'(words_loaded), 32'd3);
    endtask

    initial begin
        rst          = 1'b0;
        start        = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        #12;
        chk("rst_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_busy",  32'(busy),         32'd0);
        chk("rst_done",  32'(done),         32'd0);
        chk("rst_err",   32'(error),        32'd0);
        chk("rst_hold",  32'(cpu_hold),     32'd1);
        chk("rst_wl",    32'(words_loaded), 32'd0);
        chk("rst_store", 32'(|stream),      32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Bad checksum: 1 word, XOR = 0x11, send 0x33.
        pulse_start();
        chk("start_busy",  32'(busy),         32'd1);
        chk("start_ready", 32'(bus.in_ready), 32'd1);
        send(8'h01, 0); send(8'h00, 0);
        send(8'h13, 0); send(8'h00, 0); send(8'h22, 0); send(8'h20, 0);
        send(8'h33, 0);
        chk("bad_err",  32'(error),        32'd1);
        chk("bad_hold", 32'(cpu_hold),     32'd1);
        chk("bad_done", 32'(done),         32'd0);
        chk("bad_wl",   32'(words_loaded), 32'd1);
        chk("bad_w0",   w(0),              32'h20220013);

        // Same image with correct checksum.
        pulse_start();
        chk("restart_err", 32'(error), 32'd0);
        send(8'h01, 0); send(8'h00, 0);
        send(8'h13, 0); send(8'h00, 0); send(8'h22, 0); send(8'h20, 0);
        send(8'h11, 0);
        chk("good_done", 32'(done),     32'd1);
        chk("good_hold", 32'(cpu_hold), 32'd0);
        chk("good_busy", 32'(busy),     32'd0);
        chk("good_w0",   w(0),          32'h20220013);
        chk("good_rest", 32'(|stream[DEPTH*WIDTH-1:32]), 32'd0);

        // Header N=0 rejected right after count_hi; no data accepted.
        pulse_start();
        send(8'h00, 0); send(8'h00, 0);
        chk("n0_err",   32'(error),        32'd1);
        chk("n0_ready", 32'(bus.in_ready), 32'd0);
        chk("n0_busy",  32'(busy),         32'd0);
        bus.in_data  = 8'h55;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("n0_ready2", 32'(bus.in_ready), 32'd0);
        chk("n0_wl",     32'(words_loaded), 32'd0);

        // Header N=1025 rejected.
        pulse_start();
        send(8'h01, 0); send(8'h04, 0);
        chk("n1025_err",   32'(error),        32'd1);
        chk("n1025_ready", 32'(bus.in_ready), 32'd0);

        // Full depth, back-to-back; XOR of 16 passes over 0..255 is 0.
        pulse_start();
        stalls = 0;
        send(8'h00, 1); send(8'h04, 1);
        for (int i = 0; i < 4096; i++) send(8'(i), 1);
        chk("full_done_before", 32'(done), 32'd0);
        send(8'h00, 0);
        chk("full_stalls", 32'(stalls),       32'd0);
        chk("full_done",   32'(done),         32'd1);
        chk("full_wl",     32'(words_loaded), 32'd1024);
        chk("full_w0",     w(0),              32'h03020100);
        chk("full_w1023",  w(1023),           32'hFFFEFDFC);

        // 3-word image without and with input gaps.
        load3(1'b0, "nogap");
        load3(1'b1, "gap");

        // Async reset mid-DATA after two words.
        pulse_start();
        send(8'h03, 0); send(8'h00, 0);
        for (int i = 0; i < 8; i++) send(8'(i + 1), 0);
        chk("mid_wl", 32'(words_loaded), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_store", 32'(|stream),      32'd0);
        chk("ar_ready", 32'(bus.in_ready), 32'd0);
        chk("ar_hold",  32'(cpu_hold),     32'd1);
        chk("ar_busy",  32'(busy),         32'd0);
        chk("ar_wl",    32'(words_loaded), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        load3(1'b0, "after_rst");

        // Reload from DONE; a mid-load start must be ignored.
        pulse_start();
        chk("rl_hold",  32'(cpu_hold),     32'd1);
        chk("rl_clear", 32'(|stream),      32'd0);
        chk("rl_wl",    32'(words_loaded), 32'd0);
        send(8'h01, 0); send(8'h00, 0); send(8'h01, 0);
        pulse_start();
        chk("rl_mid_busy",  32'(busy),         32'd1);
        chk("rl_mid_ready", 32'(bus.in_ready), 32'd1);
        send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
        chk("rl_hold_load", 32'(cpu_hold), 32'd1);
        chk("rl_done_pre",  32'(done),     32'd0);
        send(8'h01, 0);
        chk("rl_done", 32'(done),     32'd1);
        chk("rl_hold_after", 32'(cpu_hold), 32'd0);
        chk("rl_w0",   w(0),          32'h00000001);
        chk("rl_w1",   w(1),          32'h00000000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-serial writer that fills the CPU's flattened instruction store: 1024 words × 32 bits, word i at bits [i*32 +: 32].
- Accepts a framed image over a valid/ready byte interface and checks it with an XOR checksum.
- Holds the CPU in reset until a complete, valid image is loaded.
- Sits between the host/UART side and cpu.instruction_stream. cpu_hold is ORed into the CPU reset at top level.

Parameters:
DEPTH, 1024, number of instruction words (power of two, ≤ 65535)
WIDTH, 32, bits per word (fixed at 32; 4 bytes per word)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  single-cycle request to begin a new load
in_data  input  8  image byte
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts a byte this cycle
instruction_stream  output  DEPTH*WIDTH  registered instruction store, word i at [i*32 +: 32]
words_loaded  output  16  count of words committed in the current load
busy  output  1  load in progress
done  output  1  image loaded and checksum OK (level)
error  output  1  load aborted (level)
cpu_hold  output  1  1 = keep CPU in reset

Behaviour:
- Reset (rst=0, async): state=IDLE; instruction_stream=0; words_loaded=0; in_ready=0; busy=0; done=0; error=0; cpu_hold=1; internal count/byte/word/checksum registers=0. Reset during a load abandons it with no partial commit beyond what reset clears.
- Handshake: a byte transfers on a rising edge with in_valid & in_ready.
  - in_ready is a registered function of state: 1 in HDR_LO, HDR_HI, DATA and CHK; 0 otherwise.
  - in_valid with in_ready=0 has no effect.
- Frame format:
  - count_lo, count_hi: 16-bit little-endian word count N.
  - N×4 data bytes: each word little-endian, byte k → bits [k*8 +: 8].
  - One checksum byte equal to the XOR of all data bytes. Header bytes are excluded.
- States:
  - IDLE: start → HDR_LO. On the same edge: instruction_stream cleared to 0, words_loaded=0, checksum=0, error=0, done=0.
  - HDR_LO: byte → count[7:0]; → HDR_HI.
  - HDR_HI: byte → count[15:8].
    - If the full 16-bit count is 0 or > DEPTH → ERROR.
    - Otherwise → DATA with byte_idx=0, word_idx=0.
  - DATA: each byte is placed into the assembly register at byte_idx and XORed into the checksum.
    - On the 4th byte (byte_idx=3), the complete word (assembly bytes 0–2 plus the current byte) is written to instruction_stream[word_idx] on that same edge.
    - On that edge, words_loaded increments and word_idx increments.
    - If word_idx == N-1, go → CHK.
    - byte_idx wraps 3→0.
  - CHK: byte == checksum → DONE; mismatch → ERROR.
  - DONE: done=1, cpu_hold=0, instruction_stream held stable. start → HDR_LO with the same clearing as IDLE; cpu_hold returns to 1 on that edge.
  - ERROR: error=1, cpu_hold=1. Partially written words remain visible. start → HDR_LO with the same clearing.
- start is ignored in HDR_LO, HDR_HI, DATA and CHK.
- busy=1 exactly in HDR_LO, HDR_HI, DATA and CHK.
- Latency: the final data word is visible in instruction_stream the cycle after its 4th byte handshake. done is asserted the cycle after the checksum byte handshake.
- Back-to-back bytes (in_valid held high) are accepted every cycle with no bubbles, including across header/data/checksum boundaries.
- N=DEPTH fills every word; word_idx never exceeds DEPTH-1.

Test Plan:
- Reset, then start; send 01 00 | 13 00 22 20 | 33 → word0 = 0x20220013; XOR = 0x13^0x00^0x22^0x20 = 0x11 ≠ 0x33 → error=1, cpu_hold=1, words_loaded=1. Repeat with checksum 0x11 → done=1, cpu_hold=0, all other words 0.
- Header 00 00 → ERROR the cycle after count_hi. Header 01 04 (N=1025) → ERROR. In both cases no data bytes are accepted (in_ready=0).
- N=1024 with data byte values = (byte index mod 256), streamed back-to-back with in_valid held high → word1023 = 0xFFFEFDFC, in_ready continuous, done after the checksum byte.
- Random in_valid gaps (50% duty) on a 3-word image → identical instruction_stream and done timing relative to the final handshake as the gap-free run.
- Assert rst=0 asynchronously mid-DATA (after 2 words) → in the same cycle instruction_stream=0, state=IDLE, in_ready=0, cpu_hold=1. A subsequent full load succeeds.
- In DONE, pulse start and send a 1-word image 01 00 | 01 00 00 00 | 01 → old contents cleared, word0 = 0x00000001, cpu_hold high during the load and low after done. A start pulse issued mid-load has no effect.
